// File: rtl/rv64g_l2_pkg.sv
// Shared definitions for the L2 directory controller: op codes, FSM states
// and the field layout of a packed directory entry.
package rv64g_l2_pkg;

  typedef enum logic [2:0] {
    DIR_OP_ALLOC      = 3'd0,
    DIR_OP_ADD_SHARER = 3'd1,
    DIR_OP_SET_OWNER  = 3'd2,
    DIR_OP_REMOVE     = 3'd3,
    DIR_OP_INVAL      = 3'd4
  } dir_op_e;

  typedef enum logic [1:0] {
    DIR_INIT,
    DIR_IDLE,
    DIR_RMW
  } dir_state_e;

  // Packed entry, LSB first: valid, sharers, owner_valid, owner_id, dirty.
  localparam int ENTRY_OFF_VALID   = 0;
  localparam int ENTRY_OFF_SHARERS = 1;

  function automatic int entry_off_owner_valid(int cores);
    return 1 + cores;
  endfunction

  function automatic int entry_off_owner_id(int cores);
    return 2 + cores;
  endfunction

  function automatic int entry_off_dirty(int cores, int cid_w);
    return 2 + cores + cid_w;
  endfunction

endpackage

// File: rtl/rv64g_l2_dir_update.sv
// Pure combinational directory-entry update: old entry plus operation gives
// the new entry and an error flag for illegal ops or failed preconditions.
module rv64g_l2_dir_update
  import rv64g_l2_pkg::*;
#(
  parameter int CORES = 4,
  parameter int CID_W = 2
) (
  input  logic             e_valid,
  input  logic [CORES-1:0] e_sharers,
  input  logic             e_owner_valid,
  input  logic [CID_W-1:0] e_owner_id,
  input  logic             e_dirty,
  input  logic [2:0]       op,
  input  logic [CID_W-1:0] core,
  input  logic             dirty,
  output logic             n_valid,
  output logic [CORES-1:0] n_sharers,
  output logic             n_owner_valid,
  output logic [CID_W-1:0] n_owner_id,
  output logic             n_dirty,
  output logic             err
);

  logic [CORES-1:0] core_bit;
  logic             owned_by_core;

  assign core_bit      = {{(CORES-1){1'b0}}, 1'b1} << core;
  assign owned_by_core = e_owner_valid && (e_owner_id == core);

  always_comb begin
    n_valid       = e_valid;
    n_sharers     = e_sharers;
    n_owner_valid = e_owner_valid;
    n_owner_id    = e_owner_id;
    n_dirty       = e_dirty;
    err           = 1'b0;
    case (op)
      DIR_OP_ALLOC: begin
        n_valid       = 1'b1;
        n_sharers     = '0;
        n_owner_valid = 1'b0;
        n_owner_id    = '0;
        n_dirty       = 1'b0;
      end
      DIR_OP_ADD_SHARER: begin
        // An owner asking to share demotes itself to the sole sharer.
        if (e_owner_valid && !owned_by_core) begin
          err = 1'b1;
        end else if (owned_by_core) begin
          n_valid       = 1'b1;
          n_owner_valid = 1'b0;
          n_dirty       = 1'b0;
          n_sharers     = core_bit;
        end else begin
          n_valid   = 1'b1;
          n_sharers = e_sharers | core_bit;
        end
      end
      DIR_OP_SET_OWNER: begin
        n_valid       = 1'b1;
        n_owner_valid = 1'b1;
        n_owner_id    = core;
        n_sharers     = '0;
        n_dirty       = dirty;
      end
      DIR_OP_REMOVE: begin
        n_sharers = e_sharers & ~core_bit;
        if (owned_by_core) begin
          n_owner_valid = 1'b0;
          n_dirty       = 1'b0;
        end
      end
      DIR_OP_INVAL: begin
        n_valid       = 1'b0;
        n_sharers     = '0;
        n_owner_valid = 1'b0;
        n_owner_id    = '0;
        n_dirty       = 1'b0;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv64g_l2_dir_ctrl.sv
// L2 directory controller: post-reset invalidation sweep, then round-robin
// arbitration of two requesters with one read-modify-write per grant.
module rv64g_l2_dir_ctrl
  import rv64g_l2_pkg::*;
#(
  parameter  int SETS    = 256,
  parameter  int WAYS    = 16,
  parameter  int CORES   = 4,
  localparam int SET_W   = $clog2(SETS),
  localparam int WAY_W   = $clog2(WAYS),
  localparam int CID_W   = $clog2(CORES),
  localparam int ENTRY_W = 3 + CORES + CID_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    init_done_o,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [2*SET_W-1:0]      req_set_i,
  input  logic [2*WAY_W-1:0]      req_way_i,
  input  logic [5:0]              req_op_i,
  input  logic [2*CID_W-1:0]      req_core_i,
  input  logic [1:0]              req_dirty_i,
  output logic                    rsp_valid_o,
  output logic                    rsp_id_o,
  output logic                    rsp_err_o,
  output logic [ENTRY_W-1:0]      rsp_prev_o,
  output logic [SET_W-1:0]        dir_rd_set_o,
  input  logic [WAYS-1:0]         dir_rd_valid_i,
  input  logic [WAYS*CORES-1:0]   dir_rd_sharers_i,
  input  logic [WAYS-1:0]         dir_rd_owner_valid_i,
  input  logic [WAYS*CID_W-1:0]   dir_rd_owner_id_i,
  input  logic [WAYS-1:0]         dir_rd_dirty_i,
  output logic                    dir_we_o,
  output logic [SET_W-1:0]        dir_wr_set_o,
  output logic [WAY_W-1:0]        dir_wr_way_o,
  output logic                    dir_wr_valid_o,
  output logic [CORES-1:0]        dir_wr_sharers_o,
  output logic                    dir_wr_owner_valid_o,
  output logic [CID_W-1:0]        dir_wr_owner_id_o,
  output logic                    dir_wr_dirty_o
);

  localparam int IDX_W    = SET_W + WAY_W;
  localparam int OFF_OV   = entry_off_owner_valid(CORES);
  localparam int OFF_OID  = entry_off_owner_id(CORES);
  localparam int OFF_DRTY = entry_off_dirty(CORES, CID_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS * WAYS - 1);

  dir_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             armed_q;
  logic             rr_q;
  logic [1:0]       grant;
  logic             hs;
  logic             hs_id;
  logic [SET_W-1:0] set_q;
  logic [WAY_W-1:0] way_q;
  logic [2:0]       op_q;
  logic [CID_W-1:0] core_q;
  logic             dirty_q;
  logic             id_q;

  logic             e_valid, e_owner_valid, e_dirty;
  logic [CORES-1:0] e_sharers;
  logic [CID_W-1:0] e_owner_id;
  logic             n_valid, n_owner_valid, n_dirty, upd_err;
  logic [CORES-1:0] n_sharers;
  logic [CID_W-1:0] n_owner_id;

  always_comb begin
    grant = 2'b00;
    if (state_q == DIR_IDLE) begin
      if (req_valid_i == 2'b11) grant = rr_q ? 2'b10 : 2'b01;
      else                      grant = req_valid_i;
    end
  end

  assign req_ready_o = grant;
  assign hs          = |grant;
  assign hs_id       = grant[1];

  assign e_valid       = dir_rd_valid_i[way_q];
  assign e_sharers     = dir_rd_sharers_i[int'(way_q)*CORES +: CORES];
  assign e_owner_valid = dir_rd_owner_valid_i[way_q];
  assign e_owner_id    = dir_rd_owner_id_i[int'(way_q)*CID_W +: CID_W];
  assign e_dirty       = dir_rd_dirty_i[way_q];

  rv64g_l2_dir_update #(.CORES(CORES), .CID_W(CID_W)) u_update (
    .e_valid       (e_valid),
    .e_sharers     (e_sharers),
    .e_owner_valid (e_owner_valid),
    .e_owner_id    (e_owner_id),
    .e_dirty       (e_dirty),
    .op            (op_q),
    .core          (core_q),
    .dirty         (dirty_q),
    .n_valid       (n_valid),
    .n_sharers     (n_sharers),
    .n_owner_valid (n_owner_valid),
    .n_owner_id    (n_owner_id),
    .n_dirty       (n_dirty),
    .err           (upd_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DIR_INIT;
    else        state_q <= state_d;
  end

  // armed_q holds the sweep off for the reset-release cycle so its first
  // write lands one cycle after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      idx_q   <= '0;
      rr_q    <= 1'b0;
      set_q   <= '0;
      way_q   <= '0;
      op_q    <= '0;
      core_q  <= '0;
      dirty_q <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (state_q == DIR_INIT && armed_q) idx_q <= idx_q + 1'b1;
      if (hs) begin
        rr_q    <= ~hs_id;
        id_q    <= hs_id;
        set_q   <= req_set_i[hs_id*SET_W +: SET_W];
        way_q   <= req_way_i[hs_id*WAY_W +: WAY_W];
        op_q    <= req_op_i[hs_id*3 +: 3];
        core_q  <= req_core_i[hs_id*CID_W +: CID_W];
        dirty_q <= req_dirty_i[hs_id];
      end
    end
  end

  always_comb begin
    state_d              = state_q;
    dir_we_o             = 1'b0;
    dir_wr_set_o         = '0;
    dir_wr_way_o         = '0;
    dir_wr_valid_o       = 1'b0;
    dir_wr_sharers_o     = '0;
    dir_wr_owner_valid_o = 1'b0;
    dir_wr_owner_id_o    = '0;
    dir_wr_dirty_o       = 1'b0;
    rsp_valid_o          = 1'b0;
    rsp_id_o             = 1'b0;
    rsp_err_o            = 1'b0;
    rsp_prev_o           = '0;
    case (state_q)
      DIR_INIT: begin
        dir_we_o     = armed_q;
        dir_wr_set_o = idx_q[IDX_W-1:WAY_W];
        dir_wr_way_o = idx_q[WAY_W-1:0];
        if (armed_q && idx_q == LAST_IDX) state_d = DIR_IDLE;
      end
      DIR_IDLE: begin
        if (hs) state_d = DIR_RMW;
      end
      DIR_RMW: begin
        dir_we_o                                 = ~upd_err;
        dir_wr_set_o                             = set_q;
        dir_wr_way_o                             = way_q;
        dir_wr_valid_o                           = n_valid;
        dir_wr_sharers_o                         = n_sharers;
        dir_wr_owner_valid_o                     = n_owner_valid;
        dir_wr_owner_id_o                        = n_owner_id;
        dir_wr_dirty_o                           = n_dirty;
        rsp_valid_o                              = 1'b1;
        rsp_id_o                                 = id_q;
        rsp_err_o                                = upd_err;
        rsp_prev_o[ENTRY_OFF_VALID]              = e_valid;
        rsp_prev_o[ENTRY_OFF_SHARERS +: CORES]   = e_sharers;
        rsp_prev_o[OFF_OV]                       = e_owner_valid;
        rsp_prev_o[OFF_OID +: CID_W]             = e_owner_id;
        rsp_prev_o[OFF_DRTY]                     = e_dirty;
        state_d                                  = DIR_IDLE;
      end
      default: state_d = DIR_INIT;
    endcase
  end

  assign init_done_o  = (state_q != DIR_INIT);
  assign dir_rd_set_o = set_q;

endmodule

// File: tb/tb_rv64g_l2_dir_ctrl.sv
// Scoreboard bench for rv64g_l2_dir_ctrl on a 4-set, 2-way, 4-core directory
// backed by a behavioural array; responses are checked against hand values.
module tb_rv64g_l2_dir_ctrl;

  localparam int SETS  = 4;
  localparam int WAYS  = 2;
  localparam int CORES = 4;
  localparam int SET_W = 2;
  localparam int WAY_W = 1;
  localparam int CID_W = 2;
  localparam int EW    = 9;

  typedef struct {
    logic [1:0] set;
    logic       way;
    logic [2:0] op;
    logic [1:0] core;
    logic       dirty;
  } req_t;

  typedef struct {
    logic          id;
    logic          err;
    logic [EW-1:0] prev;
    logic          we;
    logic [1:0]    set;
    logic          way;
    logic [EW-1:0] nxt;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  init_done_o;
  logic [1:0]            req_valid_i = '0;
  logic [1:0]            req_ready_o;
  logic [2*SET_W-1:0]    req_set_i = '0;
  logic [2*WAY_W-1:0]    req_way_i = '0;
  logic [5:0]            req_op_i = '0;
  logic [2*CID_W-1:0]    req_core_i = '0;
  logic [1:0]            req_dirty_i = '0;
  logic                  rsp_valid_o, rsp_id_o, rsp_err_o;
  logic [EW-1:0]         rsp_prev_o;
  logic [SET_W-1:0]      dir_rd_set_o;
  logic [WAYS-1:0]       dir_rd_valid_i, dir_rd_owner_valid_i, dir_rd_dirty_i;
  logic [WAYS*CORES-1:0] dir_rd_sharers_i;
  logic [WAYS*CID_W-1:0] dir_rd_owner_id_i;
  logic                  dir_we_o;
  logic [SET_W-1:0]      dir_wr_set_o;
  logic [WAY_W-1:0]      dir_wr_way_o;
  logic                  dir_wr_valid_o, dir_wr_owner_valid_o, dir_wr_dirty_o;
  logic [CORES-1:0]      dir_wr_sharers_o;
  logic [CID_W-1:0]      dir_wr_owner_id_o;
  logic [EW-1:0]         wr_ent;

  logic [EW-1:0] mem [SETS*WAYS];
  req_t          pend0 [$];
  req_t          pend1 [$];
  exp_t          sb [$];
  int            rsp_cyc [$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  exp_t          mon_ex;

  rv64g_l2_dir_ctrl #(.SETS(SETS), .WAYS(WAYS), .CORES(CORES)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .init_done_o          (init_done_o),
    .req_valid_i          (req_valid_i),
    .req_ready_o          (req_ready_o),
    .req_set_i            (req_set_i),
    .req_way_i            (req_way_i),
    .req_op_i             (req_op_i),
    .req_core_i           (req_core_i),
    .req_dirty_i          (req_dirty_i),
    .rsp_valid_o          (rsp_valid_o),
    .rsp_id_o             (rsp_id_o),
    .rsp_err_o            (rsp_err_o),
    .rsp_prev_o           (rsp_prev_o),
    .dir_rd_set_o         (dir_rd_set_o),
    .dir_rd_valid_i       (dir_rd_valid_i),
    .dir_rd_sharers_i     (dir_rd_sharers_i),
    .dir_rd_owner_valid_i (dir_rd_owner_valid_i),
    .dir_rd_owner_id_i    (dir_rd_owner_id_i),
    .dir_rd_dirty_i       (dir_rd_dirty_i),
    .dir_we_o             (dir_we_o),
    .dir_wr_set_o         (dir_wr_set_o),
    .dir_wr_way_o         (dir_wr_way_o),
    .dir_wr_valid_o       (dir_wr_valid_o),
    .dir_wr_sharers_o     (dir_wr_sharers_o),
    .dir_wr_owner_valid_o (dir_wr_owner_valid_o),
    .dir_wr_owner_id_o    (dir_wr_owner_id_o),
    .dir_wr_dirty_o       (dir_wr_dirty_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign wr_ent = {dir_wr_dirty_o, dir_wr_owner_id_o, dir_wr_owner_valid_o,
                   dir_wr_sharers_o, dir_wr_valid_o};

  // Directory storage: combinational whole-set read, clocked write.
  always @(posedge clk) begin
    if (dir_we_o) mem[int'(dir_wr_set_o)*WAYS + int'(dir_wr_way_o)] <= wr_ent;
  end

  always_comb begin
    dir_rd_valid_i       = '0;
    dir_rd_sharers_i     = '0;
    dir_rd_owner_valid_i = '0;
    dir_rd_owner_id_i    = '0;
    dir_rd_dirty_i       = '0;
    for (int w = 0; w < WAYS; w++) begin
      logic [EW-1:0] ent;
      ent = mem[int'(dir_rd_set_o)*WAYS + w];
      dir_rd_valid_i[w]                  = ent[0];
      dir_rd_sharers_i[w*CORES +: CORES] = ent[4:1];
      dir_rd_owner_valid_i[w]            = ent[5];
      dir_rd_owner_id_i[w*CID_W +: CID_W] = ent[7:6];
      dir_rd_dirty_i[w]                  = ent[8];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response pops the oldest expectation; writes outside
  // a response after the sweep are never legal.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid_o) begin
        if (sb.size() == 0) begin
          checkOutput("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
        end else begin
          mon_ex = sb.pop_front();
          rsp_cyc.push_back(cyc);
          checkOutput("rsp_id", 32'(rsp_id_o), 32'(mon_ex.id));
          checkOutput("rsp_err", 32'(rsp_err_o), 32'(mon_ex.err));
          checkOutput("rsp_prev", 32'(rsp_prev_o), 32'(mon_ex.prev));
          checkOutput("dir_we", 32'(dir_we_o), 32'(mon_ex.we));
          if (mon_ex.we) begin
            checkOutput("wr_addr", 32'({dir_wr_set_o, dir_wr_way_o}), 32'({mon_ex.set, mon_ex.way}));
            checkOutput("wr_entry", 32'(wr_ent), 32'(mon_ex.nxt));
          end
        end
      end else if (init_done_o) begin
        checkOutput("stray_write", 32'(dir_we_o), 32'd0);
      end
    end
  end

  task automatic queueReq(input int r, input logic [1:0] set, input logic way,
                          input logic [2:0] op, input logic [1:0] core, input logic dirty,
                          input logic err, input logic [EW-1:0] prev, input logic [EW-1:0] nxt);
    req_t q;
    exp_t e;
    q.set = set; q.way = way; q.op = op; q.core = core; q.dirty = dirty;
    e.id = 1'(r); e.err = err; e.prev = prev; e.we = ~err;
    e.set = set; e.way = way; e.nxt = nxt;
    if (r == 0) pend0.push_back(q);
    else        pend1.push_back(q);
    sb.push_back(e);
  endtask

  task automatic driveSlot(input int r, input req_t q);
    req_valid_i[r]            = 1'b1;
    req_set_i[r*SET_W +: SET_W] = q.set;
    req_way_i[r*WAY_W +: WAY_W] = q.way;
    req_op_i[r*3 +: 3]        = q.op;
    req_core_i[r*CID_W +: CID_W] = q.core;
    req_dirty_i[r]            = q.dirty;
  endtask

  // Presents the head of each requester queue until accepted, then waits
  // for the scoreboard to drain.
  task automatic applyStimulus();
    int budget = 0;
    int n = 0;
    logic [1:0] hs;
    while ((pend0.size() != 0 || pend1.size() != 0) && budget < 100) begin
      @(negedge clk);
      req_valid_i = '0;
      if (pend0.size() != 0) driveSlot(0, pend0[0]);
      if (pend1.size() != 0) driveSlot(1, pend1[0]);
      #1;
      hs = req_valid_i & req_ready_o;
      @(posedge clk);
      if (hs[0]) void'(pend0.pop_front());
      if (hs[1]) void'(pend1.pop_front());
      budget++;
    end
    if (pend0.size() != 0 || pend1.size() != 0) begin
      checkOutput("stim_timeout", 32'(pend0.size() + pend1.size()), 32'd0);
      pend0.delete();
      pend1.delete();
    end
    @(negedge clk);
    req_valid_i = '0;
    #1;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Holds reset, releases it, and follows the full invalidation sweep with
  // both requesters pushing so that ready must stay low throughout.
  task automatic resetAndSweep();
    logic [31:0] exp_v;
    rst_n       = 1'b0;
    req_valid_i = 2'b11;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs",
                32'({rsp_valid_o, rsp_id_o, rsp_err_o, rsp_prev_o, dir_we_o, dir_rd_set_o,
                     init_done_o, req_ready_o, wr_ent, dir_wr_set_o, dir_wr_way_o}), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("release_cycle", 32'({dir_we_o, req_ready_o, init_done_o, rsp_valid_o}), 32'd0);
    for (int c = 1; c <= SETS*WAYS; c++) begin
      @(negedge clk);
      exp_v = 32'({1'b0, 2'b00, 1'b1, 2'((c-1)/WAYS), 1'((c-1)%WAYS), 9'h000});
      checkOutput("sweep_step",
                  32'({init_done_o, req_ready_o, dir_we_o, dir_wr_set_o, dir_wr_way_o, wr_ent}), exp_v);
    end
    @(negedge clk);
    checkOutput("init_done", 32'({init_done_o, dir_we_o}), 32'b10);
    req_valid_i = '0;
    for (int i = 0; i < SETS*WAYS; i++) checkOutput("swept_entry", 32'(mem[i]), 32'd0);
  endtask

  initial begin
    $display("[TB] start");
    resetAndSweep();

    // Both requesters busy: grants alternate 0,1,0,1 from pointer 0.
    rsp_cyc.delete();
    queueReq(0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 9'h000, 9'h001);
    queueReq(1, 2'd2, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 9'h000, 9'h001);
    queueReq(0, 2'd0, 1'b0, 3'd1, 2'd3, 1'b0, 1'b0, 9'h001, 9'h011);
    queueReq(1, 2'd2, 1'b1, 3'd2, 2'd2, 1'b0, 1'b0, 9'h001, 9'h0A1);
    applyStimulus();
    for (int i = 1; i < 4; i++) checkOutput("rr_gap", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd2);

    // Sharer accumulation on s1w0.
    queueReq(0, 2'd1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 9'h000, 9'h001);
    queueReq(1, 2'd1, 1'b0, 3'd1, 2'd2, 1'b0, 1'b0, 9'h001, 9'h009);
    queueReq(0, 2'd1, 1'b0, 3'd1, 2'd0, 1'b0, 1'b0, 9'h009, 9'h00B);
    applyStimulus();

    // Dirty owner blocks a foreign sharer; the entry must be left alone.
    queueReq(1, 2'd1, 1'b1, 3'd2, 2'd1, 1'b1, 1'b0, 9'h000, 9'h161);
    queueReq(0, 2'd1, 1'b1, 3'd1, 2'd3, 1'b0, 1'b1, 9'h161, 9'h000);
    applyStimulus();
    checkOutput("err_entry_kept", 32'(mem[3]), 32'h161);

    queueReq(1, 2'd1, 1'b1, 3'd3, 2'd1, 1'b0, 1'b0, 9'h161, 9'h041);
    queueReq(1, 2'd1, 1'b1, 3'd6, 2'd1, 1'b0, 1'b1, 9'h041, 9'h000);
    applyStimulus();
    checkOutput("illegal_op_kept", 32'(mem[3]), 32'h041);

    // Owner demotes to sharer, then invalidate; remove one sharer; realloc.
    queueReq(0, 2'd3, 1'b0, 3'd2, 2'd2, 1'b1, 1'b0, 9'h000, 9'h1A1);
    queueReq(0, 2'd3, 1'b0, 3'd1, 2'd2, 1'b0, 1'b0, 9'h1A1, 9'h089);
    queueReq(0, 2'd3, 1'b0, 3'd4, 2'd0, 1'b0, 1'b0, 9'h089, 9'h000);
    applyStimulus();
    queueReq(1, 2'd1, 1'b0, 3'd3, 2'd0, 1'b0, 1'b0, 9'h00B, 9'h009);
    queueReq(1, 2'd0, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0, 9'h011, 9'h001);
    applyStimulus();

    // Reset lands in the RMW cycle of an accepted request: no response.
    @(negedge clk);
    driveSlot(0, '{set: 2'd0, way: 1'b1, op: 3'd2, core: 2'd1, dirty: 1'b1});
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    req_valid_i = '0;
    @(negedge clk);
    checkOutput("abort_no_rsp", 32'({rsp_valid_o, dir_we_o, init_done_o}), 32'd0);
    resetAndSweep();

    // Pointer is back at 0 after reset, and the sweep wiped s0w0.
    queueReq(0, 2'd0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 9'h000, 9'h001);
    queueReq(1, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 9'h000, 9'h001);
    applyStimulus();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
